// File: rtl/qam_tx_ctrl.sv
// Transmit sequencer ahead of the 16-QAM modulator: carrier warm-up, preamble, payload nibbles, flush.
// Defining QAM_TX_UNDERRUN_CNT_EN adds the underrun_cnt output and its counter.
module qam_tx_ctrl #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned WARMUP_CYC   = 16,
  parameter int unsigned FLUSH_CYC    = 32
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        sym_valid,
  output logic [3:0]  sym_data,
  input  logic        sym_ready,
  output logic        cor_en,
  output logic        busy,
`ifdef QAM_TX_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic        frame_done
);

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StPreamble,
    StPayload,
    StFlush
  } state_e;

  localparam logic [7:0] WarmLast  = 8'(WARMUP_CYC - 1);
  localparam logic [7:0] FlushLast = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] PreLast   = 8'(PREAMBLE_LEN - 1);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_pre_idx, w_pre_idx_nxt;
  logic [7:0] r_buf_data, w_buf_data_nxt;
  logic       r_buf_last, w_buf_last_nxt;
  logic       r_buf_full, w_buf_full_nxt;
  logic       r_nib_sel, w_nib_sel_nxt;
  logic       w_warm_entry;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_pre_idx  <= 8'd0;
      r_buf_data <= 8'd0;
      r_buf_last <= 1'b0;
      r_buf_full <= 1'b0;
      r_nib_sel  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pre_idx  <= w_pre_idx_nxt;
      r_buf_data <= w_buf_data_nxt;
      r_buf_last <= w_buf_last_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_nib_sel  <= w_nib_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pre_idx_nxt  = r_pre_idx;
    w_buf_data_nxt = r_buf_data;
    w_buf_last_nxt = r_buf_last;
    w_buf_full_nxt = r_buf_full;
    w_nib_sel_nxt  = r_nib_sel;
    w_warm_entry   = 1'b0;
    s_ready        = 1'b0;
    sym_valid      = 1'b0;
    sym_data       = 4'h0;
    cor_en         = 1'b0;
    busy           = 1'b0;
    frame_done     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (s_valid) begin
          w_state_nxt  = StWarmup;
          w_cnt_nxt    = 8'd0;
          w_warm_entry = 1'b1;
        end
      end
      StWarmup: begin
        cor_en  = 1'b1;
        busy    = 1'b1;
        // Prefetch the first byte so payload follows the preamble without a bubble.
        s_ready = !r_buf_full;
        if (r_cnt == WarmLast) begin
          w_state_nxt   = StPreamble;
          w_cnt_nxt     = 8'd0;
          w_pre_idx_nxt = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StPreamble: begin
        cor_en    = 1'b1;
        busy      = 1'b1;
        s_ready   = !r_buf_full;
        sym_valid = 1'b1;
        sym_data  = r_pre_idx[0] ? 4'hF : 4'h0;
        if (sym_ready) begin
          if (r_pre_idx == PreLast) begin
            w_state_nxt   = StPayload;
            w_pre_idx_nxt = 8'd0;
          end else begin
            w_pre_idx_nxt = r_pre_idx + 8'd1;
          end
        end
      end
      StPayload: begin
        cor_en    = 1'b1;
        busy      = 1'b1;
        sym_valid = r_buf_full;
        if (r_buf_full) begin
          sym_data = r_nib_sel ? r_buf_data[3:0] : r_buf_data[7:4];
        end
        // Refill in the low-nibble handshake cycle, except after the frame's last byte.
        s_ready = !r_buf_full || (r_nib_sel && sym_ready && !r_buf_last);
        if (r_buf_full && sym_ready) begin
          if (!r_nib_sel) begin
            w_nib_sel_nxt = 1'b1;
          end else begin
            w_buf_full_nxt = 1'b0;
            w_buf_last_nxt = 1'b0;
            if (r_buf_last) begin
              w_state_nxt = StFlush;
              w_cnt_nxt   = 8'd0;
            end
          end
        end
      end
      StFlush: begin
        cor_en = 1'b1;
        busy   = 1'b1;
        if (r_cnt == FlushLast) begin
          frame_done  = 1'b1;
          w_state_nxt = StIdle;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (s_valid && s_ready) begin
      w_buf_data_nxt = s_data;
      w_buf_last_nxt = s_last;
      w_buf_full_nxt = 1'b1;
      w_nib_sel_nxt  = 1'b0;
    end
  end

`ifdef QAM_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_underrun_cnt <= 16'd0;
    end else if (w_warm_entry) begin
      r_underrun_cnt <= 16'd0;
    end else if ((r_state == StPayload) && !r_buf_full && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
